// File: rtl/pc_sequencer.sv
// Program-counter register and fetch-sequencing FSM. Drives the next-PC mux
// select, registers the mux result as the PC, and counts run cycles/retires.
module pc_sequencer #(
   parameter int             PW         = 8,
   parameter int             CW         = 16,
   parameter logic [PW-1:0]  START_ADDR = '0
) (
   input  logic          i_Clk,
   input  logic          i_Reset,
   input  logic          i_Start,
   input  logic          i_Stall,
   input  logic          i_Branch,
   input  logic          i_Cond,
   input  logic          i_Jump,
   input  logic          i_Halt,
   input  logic [PW-1:0] i_NextPc,
   output logic [1:0]    o_PcSel,
   output logic [PW-1:0] o_Pc,
   output logic          o_Busy,
   output logic          o_Done,
   output logic [CW-1:0] o_Cycles,
   output logic [CW-1:0] o_InstCount
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   localparam logic [1:0] SEL_SEQ  = 2'b00;
   localparam logic [1:0] SEL_BR   = 2'b01;
   localparam logic [1:0] SEL_JMP  = 2'b10;
   localparam logic [1:0] SEL_HOLD = 2'b11;

   state_t state, state_nxt;

   logic run_adv;
   logic run_retire;
   logic cyc_sat;
   logic ins_sat;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_Start) state_nxt = RUN;
         RUN:     if (i_Halt)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Select priority in RUN: halt, stall, jump, taken branch, sequential.
   always_comb begin
      o_PcSel = SEL_HOLD;
      o_Busy  = (state == RUN);
      o_Done  = (state == DONE);
      if (state == RUN) begin
         if (i_Halt || i_Stall)      o_PcSel = SEL_HOLD;
         else if (i_Jump)            o_PcSel = SEL_JMP;
         else if (i_Branch && i_Cond) o_PcSel = SEL_BR;
         else                        o_PcSel = SEL_SEQ;
      end
   end

   assign run_adv    = (state == RUN) && !i_Halt && !i_Stall;
   assign run_retire = (state == RUN) && (i_Halt || !i_Stall);
   assign cyc_sat    = &o_Cycles;
   assign ins_sat    = &o_InstCount;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         o_Pc        <= '0;
         o_Cycles    <= '0;
         o_InstCount <= '0;
      end else if (state == IDLE) begin
         if (i_Start) begin
            o_Pc        <= START_ADDR;
            o_Cycles    <= '0;
            o_InstCount <= '0;
         end
      end else if (state == RUN) begin
         if (run_adv)                o_Pc        <= i_NextPc;
         if (!cyc_sat)               o_Cycles    <= o_Cycles + 1'b1;
         if (run_retire && !ins_sat) o_InstCount <= o_InstCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: three instances (two start addresses, a
// narrow-counter variant) share control inputs; each has its own next-PC mux.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, stall = 1'b0, branch = 1'b0, cond = 1'b0;
   logic       jump = 1'b0, halt = 1'b0;
   logic [7:0] lut = '0, off = '0;

   logic [1:0]  sel_a, sel_b, sel_c;
   logic [7:0]  pc_a, pc_b, pc_c, np_a, np_b, np_c;
   logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
   logic [15:0] cyc_a, ins_a, cyc_b, ins_b;
   logic [3:0]  cyc_c, ins_c;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          inst;
      logic [7:0]  pc;
      logic        busy;
      logic        done;
      logic [15:0] cyc;
      logic [15:0] ins;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [7:0] nmux(logic [1:0] s, logic [7:0] pc,
                                       logic [7:0] o, logic [7:0] l);
      case (s)
         2'b00:   return pc + 8'd1;
         2'b01:   return pc + o;
         2'b10:   return l;
         default: return pc;
      endcase
   endfunction

   assign np_a = nmux(sel_a, pc_a, off, lut);
   assign np_b = nmux(sel_b, pc_b, off, lut);
   assign np_c = nmux(sel_c, pc_c, off, lut);

   pc_sequencer #(.PW(8), .CW(16), .START_ADDR(8'h10)) u_a (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Stall(stall),
      .i_Branch(branch), .i_Cond(cond), .i_Jump(jump), .i_Halt(halt),
      .i_NextPc(np_a), .o_PcSel(sel_a), .o_Pc(pc_a), .o_Busy(busy_a),
      .o_Done(done_a), .o_Cycles(cyc_a), .o_InstCount(ins_a));

   pc_sequencer #(.PW(8), .CW(16), .START_ADDR(8'hFE)) u_b (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Stall(stall),
      .i_Branch(branch), .i_Cond(cond), .i_Jump(jump), .i_Halt(halt),
      .i_NextPc(np_b), .o_PcSel(sel_b), .o_Pc(pc_b), .o_Busy(busy_b),
      .o_Done(done_b), .o_Cycles(cyc_b), .o_InstCount(ins_b));

   pc_sequencer #(.PW(8), .CW(4), .START_ADDR(8'h10)) u_c (
      .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Stall(stall),
      .i_Branch(branch), .i_Cond(cond), .i_Jump(jump), .i_Halt(halt),
      .i_NextPc(np_c), .o_PcSel(sel_c), .o_Pc(pc_c), .o_Busy(busy_c),
      .o_Done(done_c), .o_Cycles(cyc_c), .o_InstCount(ins_c));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int inst, input logic [7:0] pc,
                       input logic busy, input logic done,
                       input logic [15:0] cyc, input logic [15:0] ins);
      exp_t e;
      e.tag = tag; e.inst = inst; e.pc = pc; e.busy = busy; e.done = done;
      e.cyc = cyc; e.ins = ins;
      sb.push_back(e);
   endtask

   task automatic sel_chk(input string tag, input logic [1:0] exp);
      #1;
      chk(tag, {30'd0, sel_a}, {30'd0, exp});
   endtask

   // Advance one edge, then retire every queued expectation against the DUTs.
   task automatic tick();
      exp_t e;
      logic [7:0]  pc;
      logic        bz, dn;
      logic [15:0] cy, in;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.inst)
            0:       begin pc = pc_a; bz = busy_a; dn = done_a; cy = cyc_a; in = ins_a; end
            1:       begin pc = pc_b; bz = busy_b; dn = done_b; cy = cyc_b; in = ins_b; end
            default: begin pc = pc_c; bz = busy_c; dn = done_c;
                           cy = {12'd0, cyc_c}; in = {12'd0, ins_c}; end
         endcase
         chk({e.tag, ".pc"},   {24'd0, pc}, {24'd0, e.pc});
         chk({e.tag, ".busy"}, {31'd0, bz}, {31'd0, e.busy});
         chk({e.tag, ".done"}, {31'd0, dn}, {31'd0, e.done});
         chk({e.tag, ".cyc"},  {16'd0, cy}, {16'd0, e.cyc});
         chk({e.tag, ".ins"},  {16'd0, in}, {16'd0, e.ins});
      end
   endtask

   initial begin
      logic [7:0] bpc;
      logic [15:0] sat;

      // Reset held with start asserted: nothing may leave IDLE.
      start = 1'b1;
      #12;
      chk("rst_pc", {24'd0, pc_a}, 32'h0);
      chk("rst_busy", {31'd0, busy_a}, 32'h0);
      chk("rst_sel", {30'd0, sel_a}, 32'h3);
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      push("idle", 0, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();

      // Sequential run; start held high through RUN and DONE must be ignored.
      start = 1'b1;
      push("start_a", 0, 8'h10, 1'b1, 1'b0, 16'd0, 16'd0);
      push("start_b", 1, 8'hFE, 1'b1, 1'b0, 16'd0, 16'd0);
      tick();
      bpc = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         sel_chk("seq_sel", 2'b00);
         push("seq_a", 0, 8'h11 + 8'(i), 1'b1, 1'b0, 16'(i + 1), 16'(i + 1));
         push("wrap_b", 1, bpc, 1'b1, 1'b0, 16'(i + 1), 16'(i + 1));
         bpc = bpc + 8'd1;
         tick();
      end
      halt = 1'b1;
      sel_chk("halt_sel", 2'b11);
      push("halt_a", 0, 8'h14, 1'b0, 1'b1, 16'd5, 16'd5);
      push("halt_b", 1, 8'h02, 1'b0, 1'b1, 16'd5, 16'd5);
      tick();
      halt = 1'b0;
      push("done_ign", 0, 8'h14, 1'b0, 1'b0, 16'd5, 16'd5);
      tick();
      push("restart_a", 0, 8'h10, 1'b1, 1'b0, 16'd0, 16'd0);
      push("restart_b", 1, 8'hFE, 1'b1, 1'b0, 16'd0, 16'd0);
      tick();
      start = 1'b0;

      // Branch / jump priority.
      sel_chk("to11_sel", 2'b00);
      push("to11", 0, 8'h11, 1'b1, 1'b0, 16'd1, 16'd1);
      tick();
      branch = 1'b1; cond = 1'b1; jump = 1'b1; lut = 8'h40;
      sel_chk("jmp_pri_sel", 2'b10);
      push("jmp_pri", 0, 8'h40, 1'b1, 1'b0, 16'd2, 16'd2);
      tick();
      branch = 1'b0; cond = 1'b0; lut = 8'h11;
      push("jmp_back", 0, 8'h11, 1'b1, 1'b0, 16'd3, 16'd3);
      tick();
      jump = 1'b0; branch = 1'b1; cond = 1'b1; off = 8'd3;
      sel_chk("br_sel", 2'b01);
      push("br_taken", 0, 8'h14, 1'b1, 1'b0, 16'd4, 16'd4);
      tick();
      jump = 1'b1; branch = 1'b0; cond = 1'b0;
      push("jmp_back2", 0, 8'h11, 1'b1, 1'b0, 16'd5, 16'd5);
      tick();
      jump = 1'b0; branch = 1'b1; cond = 1'b0;
      sel_chk("br_nt_sel", 2'b00);
      push("br_nt", 0, 8'h12, 1'b1, 1'b0, 16'd6, 16'd6);
      tick();

      // Stalls, then halt coincident with stall.
      branch = 1'b0; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel_chk("stall_sel", 2'b11);
         push("stall", 0, 8'h12, 1'b1, 1'b0, 16'(7 + i), 16'd6);
         tick();
      end
      halt = 1'b1;
      push("halt_stall", 0, 8'h12, 1'b0, 1'b1, 16'd10, 16'd7);
      tick();
      halt = 1'b0; stall = 1'b0;
      push("hold_a", 0, 8'h12, 1'b0, 1'b0, 16'd10, 16'd7);
      push("hold_c", 2, 8'h12, 1'b0, 1'b0, 16'd10, 16'd7);
      tick();

      // Saturation on the narrow-counter instance.
      start = 1'b1;
      push("sat_start", 2, 8'h10, 1'b1, 1'b0, 16'd0, 16'd0);
      tick();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sat = (i + 1 > 15) ? 16'd15 : 16'(i + 1);
         push("sat_run", 2, 8'h11 + 8'(i), 1'b1, 1'b0, sat, sat);
         tick();
      end
      halt = 1'b1;
      push("sat_halt_c", 2, 8'h24, 1'b0, 1'b1, 16'hF, 16'hF);
      push("sat_halt_a", 0, 8'h24, 1'b0, 1'b1, 16'd21, 16'd21);
      tick();
      halt = 1'b0;
      push("sat_hold", 2, 8'h24, 1'b0, 1'b0, 16'hF, 16'hF);
      tick();

      // Asynchronous reset mid-cycle while running at 2A.
      start = 1'b1;
      push("rr_start", 0, 8'h10, 1'b1, 1'b0, 16'd0, 16'd0);
      tick();
      start = 1'b0; jump = 1'b1; lut = 8'h2A;
      push("rr_jmp", 0, 8'h2A, 1'b1, 1'b0, 16'd1, 16'd1);
      tick();
      #3;
      rst = 1'b1; start = 1'b1;
      #1;
      chk("arst_pc", {24'd0, pc_a}, 32'h0);
      chk("arst_busy", {31'd0, busy_a}, 32'h0);
      chk("arst_sel", {30'd0, sel_a}, 32'h3);
      chk("arst_cyc", {16'd0, cyc_a}, 32'h0);
      @(posedge clk); #1;
      chk("arst_start_lost", {31'd0, busy_a}, 32'h0);
      rst = 1'b0; start = 1'b0; jump = 1'b0;
      push("post_rst", 0, 8'h00, 1'b0, 1'b0, 16'd0, 16'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
